// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared types and constants for the Tetris game-flow sequencer.
//   - ROWS / ROW_W : playfield height and row index width
//   - seq_state_t  : sequencer FSM states (also exported as a debug port)
//   - line_score() : points per line-clear count, only built when SCORE_EN
//                    is defined
package tetris_pkg;

  localparam int ROWS  = 20;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SPAWN       = 4'd1,
    SPAWN_CHK   = 4'd2,
    FALL        = 4'd3,
    LOCK_WAIT   = 4'd4,
    CLEAR_SCAN  = 4'd5,
    CLEAR_SHIFT = 4'd6,
    CLEAR_DONE  = 4'd7,
    GAME_OVER   = 4'd8
  } seq_state_t;

`ifdef SCORE_EN
  // Base points for clearing 0..4 lines in one lock; scaled by (level+1).
  function automatic logic [10:0] line_score(input logic [2:0] n);
    logic [10:0] pts;
    case (n)
      3'd1:    pts = 11'd40;
      3'd2:    pts = 11'd100;
      3'd3:    pts = 11'd300;
      3'd4:    pts = 11'd1200;
      default: pts = 11'd0;
    endcase
    return pts;
  endfunction
`endif

endpackage

// File: rtl/gravity_timer.sv
// gravity_timer
//   Counts gravity ticks for the falling piece and issues a one-cycle drop
//   strobe when the level-dependent period elapses, or on every tick while
//   soft_drop is held.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     clear           : synchronous counter clear (new game)
//     run             : counting allowed (piece falling and not touching)
//     tick            : one-cycle gravity tick strobe
//     soft_drop       : drop on every tick
//     level[4:0]      : current level, sets period = max(GRAV_MIN, GRAV_BASE-level)
//     drop            : combinational drop strobe, coincident with the tick
module gravity_timer #(
  parameter int GRAV_BASE = 16,
  parameter int GRAV_MIN  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic       tick,
  input  logic       soft_drop,
  input  logic [4:0] level,
  output logic       drop
);

  localparam int CW = $clog2(GRAV_BASE + 1);

  logic [CW-1:0] grav_cnt;
  logic [CW-1:0] period;
  logic [CW:0]   cnt_inc;

  // Clamp before subtracting so high levels never wrap the period.
  always_comb begin
    if (int'(level) + GRAV_MIN >= GRAV_BASE) period = CW'(GRAV_MIN);
    else                                     period = CW'(GRAV_BASE - int'(level));
  end

  assign cnt_inc = {1'b0, grav_cnt} + (CW+1)'(1);
  assign drop    = run & tick & (soft_drop | (cnt_inc >= {1'b0, period}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grav_cnt <= '0;
    end else if (clear) begin
      grav_cnt <= '0;
    end else if (run && tick) begin
      if (drop) grav_cnt <= '0;
      else      grav_cnt <= cnt_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
//   Game-flow controller: spawn, gravity drops, lock delay, row-by-row line
//   clearing, level/line bookkeeping and game-over.
//   Optional build macro: SCORE_EN (adds the score output and scoring logic).
//   Ports:
//     clk, reset     : clock, asynchronous active-low reset
//     tick           : one-cycle gravity tick
//     start          : begin a game from IDLE or GAME_OVER
//     soft_drop      : drop on every tick while high
//     touching       : active piece rests on stack/floor
//     spawn_blocked  : freshly spawned piece overlaps fixed cells
//     row_full       : row at row_sel is fully occupied
//     spawn_en/drop_en/lock_en/shift_en : datapath enable strobes
//     row_sel        : row under test / shift boundary
//     playing, game_over : status
//     level, lines   : current level (sat. 31), total cleared lines (sat.)
//     score          : (SCORE_EN only) saturating score
//     seq_state      : FSM state, for debug and checkers
//
//   Strobe semantics: every *_en output is a single-cycle pulse with no
//   backpressure; at most one of them is high in any cycle. spawn_en and
//   shift_en are decoded from state; drop_en and lock_en are qualified by the
//   tick of the same cycle.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int GRAV_BASE       = 16,
  parameter int GRAV_MIN        = 1,
  parameter int LOCK_TICKS      = 2,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             soft_drop,
  input  logic             touching,
  input  logic             spawn_blocked,
  input  logic             row_full,
  output logic             spawn_en,
  output logic             drop_en,
  output logic             lock_en,
  output logic [ROW_W-1:0] row_sel,
  output logic             shift_en,
  output logic             playing,
  output logic             game_over,
  output logic [4:0]       level,
  output logic [15:0]      lines,
`ifdef SCORE_EN
  output logic [23:0]      score,
`endif
  output seq_state_t       seq_state
);

  localparam int LW = $clog2(LOCK_TICKS + 1);

  seq_state_t     state, state_d;
  logic [LW-1:0]  lock_cnt;
  logic [LW:0]    lock_nxt;
  logic           lock_hit;
  logic [2:0]     cleared;
  logic [16:0]    lines_sum;
  logic [15:0]    next_thresh;
  logic           game_start;
  logic           timer_run;

  assign seq_state  = state;
  assign game_start = start && ((state == IDLE) || (state == GAME_OVER));
  assign timer_run  = (state == FALL) && !touching;
  assign lock_nxt   = {1'b0, lock_cnt} + (LW+1)'(1);
  assign lock_hit   = lock_nxt >= (LW+1)'(LOCK_TICKS);
  assign lines_sum  = {1'b0, lines} + {14'd0, cleared};

  gravity_timer #(
    .GRAV_BASE (GRAV_BASE),
    .GRAV_MIN  (GRAV_MIN)
  ) u_gravity_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (game_start),
    .run       (timer_run),
    .tick      (tick),
    .soft_drop (soft_drop),
    .level     (level),
    .drop      (drop_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    spawn_en  = 1'b0;
    lock_en   = 1'b0;
    shift_en  = 1'b0;
    playing   = 1'b0;
    game_over = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = SPAWN;
      end
      SPAWN: begin
        playing  = 1'b1;
        spawn_en = 1'b1;
        state_d  = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        playing = 1'b1;
        state_d = spawn_blocked ? GAME_OVER : FALL;
      end
      FALL: begin
        playing = 1'b1;
        if (tick && touching) state_d = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        playing = 1'b1;
        // A lateral move off the ledge cancels the lock delay.
        if (!touching) begin
          state_d = FALL;
        end else if (tick && lock_hit) begin
          lock_en = 1'b1;
          state_d = CLEAR_SCAN;
        end
      end
      CLEAR_SCAN: begin
        playing = 1'b1;
        if (row_full)            state_d = CLEAR_SHIFT;
        else if (row_sel == '0)  state_d = CLEAR_DONE;
      end
      CLEAR_SHIFT: begin
        playing  = 1'b1;
        shift_en = 1'b1;
        state_d  = CLEAR_SCAN;
      end
      CLEAR_DONE: begin
        playing = 1'b1;
        state_d = SPAWN;
      end
      GAME_OVER: begin
        game_over = 1'b1;
        // Restart clears the same bookkeeping as a start from IDLE, then
        // spawns directly so a one-cycle start pulse is enough.
        if (start) state_d = SPAWN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock delay counter, row scan pointer and per-lock cleared-line count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
      row_sel  <= ROW_W'(ROWS - 1);
      cleared  <= '0;
    end else begin
      if (game_start) begin
        lock_cnt <= '0;
        row_sel  <= ROW_W'(ROWS - 1);
        cleared  <= '0;
      end
      case (state)
        FALL: begin
          if (tick && touching) lock_cnt <= '0;
        end
        LOCK_WAIT: begin
          if (touching && tick) begin
            lock_cnt <= lock_nxt[LW-1:0];
            if (lock_hit) begin
              row_sel <= ROW_W'(ROWS - 1);
              cleared <= '0;
            end
          end
        end
        CLEAR_SCAN: begin
          if (!row_full && (row_sel != '0)) row_sel <= row_sel - ROW_W'(1);
        end
        CLEAR_SHIFT: begin
          // row_sel stays put: the row above has just moved into it.
          cleared <= (cleared == 3'd4) ? 3'd4 : cleared + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Lines and level. Level catches up one step per cycle whenever lines has
  // reached the next threshold, avoiding a divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lines       <= '0;
      level       <= '0;
      next_thresh <= 16'(LINES_PER_LEVEL);
    end else if (game_start) begin
      lines       <= '0;
      level       <= '0;
      next_thresh <= 16'(LINES_PER_LEVEL);
    end else begin
      if (state == CLEAR_DONE) lines <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
      if ((level != 5'd31) && (lines >= next_thresh)) begin
        level       <= level + 5'd1;
        next_thresh <= next_thresh + 16'(LINES_PER_LEVEL);
      end
    end
  end

`ifdef SCORE_EN
  logic [16:0] clear_pts;
  logic [23:0] score_add;
  logic [24:0] score_sum;

  assign clear_pts = 17'({1'b0, level} + 6'd1) * 17'(line_score(cleared));

  always_comb begin
    score_add = '0;
    if (state == CLEAR_DONE)       score_add = 24'(clear_pts);
    else if (drop_en && soft_drop) score_add = 24'd1;
  end

  assign score_sum = {1'b0, score} + {1'b0, score_add};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          score <= '0;
    else if (game_start) score <= '0;
    else                 score <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
  end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed bench for game_sequencer. Inputs change at the falling edge,
//   outputs are sampled 1 ns later; the rising edge commits the cycle.
//   A row model of full-row flags feeds row_full and collapses on shift_en.
module tb_game_sequencer;
  import tetris_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk           = 1'b0;
  logic reset         = 1'b0;
  logic tick          = 1'b0;
  logic start         = 1'b0;
  logic soft_drop     = 1'b0;
  logic touching      = 1'b0;
  logic spawn_blocked = 1'b0;
  logic row_full;

  logic             spawn_en, drop_en, lock_en, shift_en;
  logic             playing, game_over;
  logic [ROW_W-1:0] row_sel;
  logic [4:0]       level;
  logic [15:0]      lines;
  seq_state_t       seq_state;
`ifdef SCORE_EN
  logic [23:0]      score;
`endif

  always #5 clk = ~clk;

  logic [31:0] rows = '0;  // bit i = row i is full
  assign row_full = rows[row_sel];

  game_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start         (start),
    .soft_drop     (soft_drop),
    .touching      (touching),
    .spawn_blocked (spawn_blocked),
    .row_full      (row_full),
    .spawn_en      (spawn_en),
    .drop_en       (drop_en),
    .lock_en       (lock_en),
    .row_sel       (row_sel),
    .shift_en      (shift_en),
    .playing       (playing),
    .game_over     (game_over),
    .level         (level),
    .lines         (lines),
`ifdef SCORE_EN
    .score         (score),
`endif
    .seq_state     (seq_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_spawn, n_drop, n_lock, n_shift;
  logic cur_spawn, cur_drop, cur_lock;
  logic [ROW_W-1:0] exp_q[$];  // expected row_sel of each shift_en

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_spawn = 0; n_drop = 0; n_lock = 0; n_shift = 0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample outputs for the inputs set by the caller, then let the
  // rising edge happen and return at the next falling edge.
  task automatic cyc();
    int n;
    logic did_shift;
    logic [ROW_W-1:0] sr, exp_row;
    #1;
    n = int'(spawn_en) + int'(drop_en) + int'(lock_en) + int'(shift_en);
    check_eq("strobe_excl", 32'(n <= 1), 1);
    n_spawn += int'(spawn_en);
    n_drop  += int'(drop_en);
    n_lock  += int'(lock_en);
    cur_spawn = spawn_en;
    cur_drop  = drop_en;
    cur_lock  = lock_en;
    did_shift = shift_en;
    sr        = row_sel;
    if (shift_en) begin
      n_shift++;
      exp_row = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check_eq("shift_row", 32'(row_sel), 32'(exp_row));
    end
    @(negedge clk);
    if (did_shift) begin
      for (int i = ROWS - 1; i > 0; i--)
        if (i <= int'(sr)) rows[i] = rows[i-1];
      rows[0] = 1'b0;
    end
  endtask

  task automatic tick_cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Lock the piece (entering tick + LOCK_TICKS ticks) with the bottom nrows
  // full, then run the clear until the next spawn. Returns at SPAWN_CHK.
  task automatic lock_and_clear(input int nrows);
    int cycles;
    logic spawned;
    rows = '0;
    for (int i = 0; i < nrows; i++) begin
      rows[ROWS-1-i] = 1'b1;
      exp_q.push_back(ROW_W'(ROWS - 1));
    end
    touching = 1'b1;
    tick_cyc();
    check_eq("enter_lock_wait", 32'(seq_state), 32'(LOCK_WAIT));
    tick_cyc();
    check_eq("lock_early", 32'(cur_lock), 0);
    tick_cyc();
    check_eq("lock_en", 32'(cur_lock), 1);
    touching = 1'b0;
    cycles  = 0;
    spawned = 1'b0;
    for (int k = 1; k <= 200 && !spawned; k++) begin
      cyc();
      if (cur_spawn) begin
        spawned = 1'b1;
        cycles  = k;
      end
    end
    check_eq("clear_spawn_seen", 32'(spawned), 1);
    // 2 cycles per shift, 20 scan cycles, DONE, then SPAWN.
    check_eq("clear_cycles", cycles, 2 * nrows + 22);
    check_eq("shift_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int drop_at, first_drop, second_drop, spawn_at;

  initial begin
    clr_counts();
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", 32'(seq_state), 32'(IDLE));
    check_eq("rst_row_sel", 32'(row_sel), ROWS - 1);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_lines", 32'(lines), 0);
    check_eq("rst_strobes", 32'({spawn_en, drop_en, lock_en, shift_en}), 0);
    check_eq("rst_status", 32'({playing, game_over}), 0);
    @(negedge clk);
    reset = 1'b1;

    // Start and spawn
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check_eq("spawn_en", 32'(cur_spawn), 1);
    cyc();
    check_eq("state_fall", 32'(seq_state), 32'(FALL));
    check_eq("playing", 32'(playing), 1);

    // 16 ticks at level 0: one drop, on the 16th tick
    clr_counts();
    drop_at = 0;
    for (int i = 1; i <= 16; i++) begin
      tick_cyc();
      if (cur_drop) drop_at = i;
      cyc();
    end
    check_eq("grav_drop_count", n_drop, 1);
    check_eq("grav_drop_tick", drop_at, 16);

    // Soft drop: one drop per tick
    soft_drop = 1'b1;
    clr_counts();
    for (int i = 0; i < 4; i++) begin
      tick_cyc();
      cyc();
    end
    soft_drop = 1'b0;
    check_eq("soft_drop_count", n_drop, 4);

    // Touching released after one lock tick: back to FALL, no lock
    clr_counts();
    touching = 1'b1;
    tick_cyc();
    tick_cyc();
    touching = 1'b0;
    cyc();
    check_eq("lock_abort_state", 32'(seq_state), 32'(FALL));
    check_eq("lock_abort_no_lock", n_lock, 0);
    check_eq("lock_abort_no_drop", n_drop, 0);

    // Lock with rows 19 and 18 full: two shifts at row 19, lines=2
    lock_and_clear(2);
    check_eq("lines_after_2", 32'(lines), 2);
    cyc();
    check_eq("back_to_fall", 32'(seq_state), 32'(FALL));

    // Two tetrises: 10 lines total, level 1
    lock_and_clear(4);
    cyc();
    lock_and_clear(4);
    cyc();
    check_eq("lines_10", 32'(lines), 10);
    check_eq("level_1", 32'(level), 1);

    // Period at level 1 is 15 ticks
    first_drop = 0;
    second_drop = 0;
    for (int i = 1; i <= 40 && second_drop == 0; i++) begin
      tick_cyc();
      if (cur_drop) begin
        if (first_drop == 0) first_drop = i;
        else second_drop = i;
      end
      cyc();
    end
    check_eq("lvl1_first_drop", first_drop, 15);
    check_eq("lvl1_period", second_drop - first_drop, 15);

    // start while playing is ignored
    clr_counts();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check_eq("start_ignored_state", 32'(seq_state), 32'(FALL));
    check_eq("start_ignored_lines", 32'(lines), 10);
    check_eq("start_ignored_spawn", n_spawn, 0);

    // Asynchronous reset mid-FALL
    tick  = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(seq_state), 32'(IDLE));
    check_eq("mid_rst_level", 32'(level), 0);
    check_eq("mid_rst_lines", 32'(lines), 0);
    check_eq("mid_rst_row_sel", 32'(row_sel), ROWS - 1);
    check_eq("mid_rst_strobes", 32'({spawn_en, drop_en, lock_en, shift_en}), 0);
    @(negedge clk);
    tick  = 1'b0;
    reset = 1'b1;

    // New game, one line, then a blocked spawn
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    lock_and_clear(1);
    cyc();
    check_eq("lines_1", 32'(lines), 1);
    lock_and_clear(0);
    spawn_blocked = 1'b1;
    cyc();
    check_eq("go_flag", 32'(game_over), 1);
    check_eq("go_playing", 32'(playing), 0);
    clr_counts();
    touching  = 1'b1;
    soft_drop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = i[0];
      cyc();
    end
    tick = 1'b0;
    touching  = 1'b0;
    soft_drop = 1'b0;
    spawn_blocked = 1'b0;
    check_eq("go_quiet", n_spawn + n_drop + n_lock + n_shift, 0);
    check_eq("go_hold", 32'(seq_state), 32'(GAME_OVER));

    // Restart from GAME_OVER: spawn within 3 cycles, bookkeeping cleared
    start = 1'b1;
    cyc();
    start = 1'b0;
    spawn_at = 0;
    for (int k = 1; k <= 3 && spawn_at == 0; k++) begin
      cyc();
      if (cur_spawn) spawn_at = k;
    end
    check_eq("restart_spawn", 32'(spawn_at >= 1 && spawn_at <= 3), 1);
    check_eq("restart_lines", 32'(lines), 0);
    check_eq("restart_level", 32'(level), 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the Tetris datapath. It sequences piece spawn, gravity drops, landing/lock, row-by-row line clearing and game-over. It drives the enables of the active-piece registers, the fixed-screen capture and the row-shift datapath. It sits between the tick/command front end and the game executioner datapath, and replaces the datapath's free-running flop-chain sequencing with an explicit FSM.

Parameters:
ROWS, 20, playfield rows; row index width is $clog2(ROWS)
GRAV_BASE, 16, gravity ticks per drop at level 0
GRAV_MIN, 1, floor on ticks per drop
LOCK_TICKS, 2, gravity ticks a touching piece waits before lock
LINES_PER_LEVEL, 10, cleared lines per level increment

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle gravity-tick strobe, synchronous to clk
start  in  1  begin game from IDLE or GAME_OVER
soft_drop  in  1  level: drop on every tick
touching  in  1  active piece rests on stack/floor (combinational from datapath)
spawn_blocked  in  1  newly spawned piece overlaps fixed cells
row_full  in  1  row at row_sel is fully occupied
spawn_en  out  1  load new piece (x, rotation, type; y=0)
drop_en  out  1  increment active piece y
lock_en  out  1  capture blitted screen into fixed screen
row_sel  out  $clog2(ROWS)  row under test/shift
shift_en  out  1  collapse rows 0..row_sel down by one; row 0 blanked
playing  out  1  high in SPAWN/FALL/LOCK_WAIT/CLEAR_*
game_over  out  1  high in GAME_OVER
level  out  5  current level, saturates at 31
lines  out  16  total cleared lines, saturating

Behaviour:
- Reset (async, reset=0): state IDLE; all strobes 0; row_sel=ROWS-1; level=0; lines=0; grav_cnt=0; lock_cnt=0.
- Only one of spawn_en/drop_en/lock_en/shift_en is high in any cycle; each is a single-cycle pulse.
- IDLE: on start go to SPAWN; clear level, lines and counters.
- SPAWN: assert spawn_en for 1 cycle, then go to SPAWN_CHK.
- SPAWN_CHK: spawn_blocked=1 -> GAME_OVER; else -> FALL.
- FALL: on tick, if touching -> LOCK_WAIT with lock_cnt=0; else increment grav_cnt; when grav_cnt+1 >= period (or soft_drop), pulse drop_en and set grav_cnt=0. period = max(GRAV_MIN, GRAV_BASE - level).
- LOCK_WAIT: if touching drops to 0 (after a lateral move), return to FALL. On tick, lock_cnt++; when it reaches LOCK_TICKS, pulse lock_en and go to CLEAR_SCAN with row_sel=ROWS-1 and cleared=0.
- CLEAR_SCAN: one row per cycle, row_full sampled the same cycle. If full -> CLEAR_SHIFT. Else, if row_sel==0 -> CLEAR_DONE; else row_sel--.
- CLEAR_SHIFT: pulse shift_en; cleared++ (3-bit, max 4); return to CLEAR_SCAN with row_sel unchanged, so the same row is re-tested after rows move down.
- CLEAR_DONE: lines += cleared (saturating). level = min(31, lines/LINES_PER_LEVEL), computed with an iterative counter, not a divider: bump level when lines crosses the next threshold. Then -> SPAWN.
- GAME_OVER: hold all strobes 0; start -> IDLE path (counters cleared) -> SPAWN.
- tick arriving in SPAWN, SPAWN_CHK or CLEAR_*: ignored, not queued.
- start while playing: ignored.
- Reset mid-clear: immediate return to IDLE. The datapath fixed screen is cleared by the same reset.

Optional Feature:
SCORE_EN. When defined, adds output score[23:0] with reset value 0, cleared on start. In CLEAR_DONE, score += (level+1) × {0,40,100,300,1200}[cleared], saturating at 24'hFFFFFF. Soft drop adds 1 per drop_en issued while soft_drop=1. When not defined, there is no score port and no scoring logic.

Decomposition:
- tetris_pkg: enum seq_state_t (IDLE, SPAWN, SPAWN_CHK, FALL, LOCK_WAIT, CLEAR_SCAN, CLEAR_SHIFT, CLEAR_DONE, GAME_OVER), constant ROWS, and the score table under SCORE_EN.
- One sub-module: gravity_timer (tick counter, period compare, soft_drop override, drop strobe).

Test Plan:
- reset low mid-FALL -> next cycle state IDLE, level=0, lines=0, all strobes 0.
- start; spawn_blocked=0; touching=0; 16 ticks at level 0 -> exactly one drop_en, on the 16th tick; with soft_drop=1, one drop_en per tick.
- touching=1 then 2 ticks -> lock_en on the 2nd tick. touching deasserted after 1 tick -> back to FALL, no lock_en.
- After lock, row_full true at rows 19 and 18 (model shifts rows) -> shift_en at row_sel=19 twice, then scan continues down to row 0; lines=2; then spawn_en.
- Accumulate 10 cleared lines -> level=1; drop period becomes 15 ticks.
- spawn_blocked=1 at SPAWN_CHK -> game_over=1, playing=0, no further strobes; start -> spawn_en within 3 cycles.
